// File: rtl/keypad_scan_pkg.sv
// -----------------------------------------------------------------------------
// keypad_scan_pkg
// Shared definitions for the 4x4 matrix keypad scanner:
//   - keypad geometry (rows, columns, number of keys, key code width)
//   - debounce FSM state encoding
//   - lowest-set-bit key encoder used to pick the winning key from a scan
// No ports (package).
// -----------------------------------------------------------------------------
package keypad_scan_pkg;

  localparam int KEY_ROWS   = 4;
  localparam int KEY_COLS   = 4;
  localparam int KEY_NUM    = KEY_ROWS * KEY_COLS;
  localparam int KEY_CODE_W = 4;

  // Debounce FSM states (2-bit encoding).
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAND    = 2'd1,
    PRESSED = 2'd2
  } kp_state_e;

  // Index of the lowest set bit; key 0 has the highest priority.
  // Returns 0 for an all-zero vector (callers qualify with |keys).
  function automatic logic [KEY_CODE_W-1:0] lowest_key(input logic [KEY_NUM-1:0] keys);
    logic [KEY_CODE_W-1:0] code;
    code = '0;
    // Walk downwards so the last hit written is the lowest index.
    for (int i = KEY_NUM - 1; i >= 0; i--) begin
      if (keys[i]) begin
        code = KEY_CODE_W'(i);
      end
    end
    return code;
  endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// -----------------------------------------------------------------------------
// keypad_scan_if
// Bundles the keypad matrix lines and the key-event outputs of keypad_scan.
//   col_in   : keypad column returns, active-low, asynchronous
//   row_out  : keypad row drive, active-low, one-hot-zero
//   key_in   : one-cycle strobe, new debounced key accepted
//   key_val  : code of the accepted key (row*4+col), held until next accept
//   key_held : high while the accepted key is considered pressed
// Modports:
//   master : the scanner (drives rows and key outputs, reads columns)
//   slave  : the keypad / downstream key buffer side
// -----------------------------------------------------------------------------
interface keypad_scan_if;

  logic [keypad_scan_pkg::KEY_COLS-1:0]   col_in;
  logic [keypad_scan_pkg::KEY_ROWS-1:0]   row_out;
  logic                                   key_in;
  logic [keypad_scan_pkg::KEY_CODE_W-1:0] key_val;
  logic                                   key_held;

  modport master (
    input  col_in,
    output row_out,
    output key_in,
    output key_val,
    output key_held
  );

  modport slave (
    output col_in,
    input  row_out,
    input  key_in,
    input  key_val,
    input  key_held
  );

endinterface

// File: rtl/keypad_scan_sync2.sv
// -----------------------------------------------------------------------------
// sync2
// Two-flop synchroniser for a bus of independent asynchronous bits.
// Ports:
//   clock  : destination clock
//   reset  : synchronous, active-high; loads RST_VAL into both stages
//   d_i    : asynchronous input bus
//   q_o    : synchronised output, 2 clocks of latency
// Parameters:
//   WIDTH   : bus width
//   RST_VAL : value both stages take in reset (the "idle" level of the input)
// -----------------------------------------------------------------------------
module sync2 #(
  parameter int              WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scan.sv
// -----------------------------------------------------------------------------
// keypad_scan
// Scans a 4x4 active-low matrix keypad one row at a time, synchronises the
// column returns, builds a 16-bit snapshot per full scan and debounces the
// lowest-indexed pressed key across consecutive scans. A debounced press
// produces exactly one key_in strobe with key_val valid in the same cycle.
// Ports:
//   clock : system clock
//   reset : synchronous, active-high, dominates every other input
//   kp    : keypad_scan_if.master (col_in, row_out, key_in, key_val, key_held)
// Parameters:
//   SCAN_DIV : clocks each row is driven before its columns are sampled (>=4)
//   DEBOUNCE : consecutive identical full scans to accept a press/release (>=1)
// -----------------------------------------------------------------------------
module keypad_scan
  import keypad_scan_pkg::*;
#(
  parameter logic [15:0] SCAN_DIV = 16'd1000,
  parameter logic [3:0]  DEBOUNCE = 4'd3
) (
  input  logic         clock,
  input  logic         reset,
  keypad_scan_if.master kp
);

  // Column synchroniser. Idle (no key) columns read high, so reset the
  // stages to all-ones to avoid a phantom full-row press after reset.
  logic [KEY_COLS-1:0] col_sync;

  sync2 #(
    .WIDTH   (KEY_COLS),
    .RST_VAL ({KEY_COLS{1'b1}})
  ) u_col_sync (
    .clock (clock),
    .reset (reset),
    .d_i   (kp.col_in),
    .q_o   (col_sync)
  );

  // Row scanner state
  logic [15:0]         div_cnt_q,   div_cnt_d;
  logic [1:0]          row_idx_q,   row_idx_d;
  logic [KEY_ROWS-1:0] row_out_q,   row_out_d;
  logic [KEY_NUM-1:0]  snap_q,      snap_d;
  logic                scan_done_q, scan_done_d;
  logic                tick;

  // Debounce FSM state and registered outputs
  kp_state_e             state_q;
  logic [3:0]            cnt_q;
  logic [KEY_CODE_W-1:0] code_q;
  logic                  key_in_q;
  logic [KEY_CODE_W-1:0] key_val_q;
  logic                  key_held_q;

  // Encoder outputs
  logic                  cand_valid;
  logic [KEY_CODE_W-1:0] cand_code;

  assign tick = (div_cnt_q == (SCAN_DIV - 16'd1));

  always_comb begin
    div_cnt_d   = div_cnt_q + 16'd1;
    row_idx_d   = row_idx_q;
    row_out_d   = row_out_q;
    snap_d      = snap_q;
    scan_done_d = 1'b0;
    if (tick) begin
      div_cnt_d = '0;
      row_idx_d = row_idx_q + 2'd1;
      row_out_d = ~(4'b0001 << row_idx_d);
      // Columns are active-low; store pressed keys as ones.
      snap_d[{row_idx_q, 2'b00} +: KEY_COLS] = ~col_sync;
      // Row 3 closes a scan; the pulse lands the clock after, when the
      // snapshot already holds row 3's sample.
      scan_done_d = (row_idx_q == 2'd3);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      div_cnt_q   <= '0;
      row_idx_q   <= '0;
      row_out_q   <= 4'b1110;
      snap_q      <= '0;
      scan_done_q <= 1'b0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      row_idx_q   <= row_idx_d;
      row_out_q   <= row_out_d;
      snap_q      <= snap_d;
      scan_done_q <= scan_done_d;
    end
  end

  assign cand_valid = |snap_q;
  assign cand_code  = lowest_key(snap_q);

  // Debounce FSM: evaluated once per completed scan. cnt counts identical
  // candidate scans in CAND and consecutive empty scans in PRESSED.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      code_q     <= '0;
      key_in_q   <= 1'b0;
      key_val_q  <= '0;
      key_held_q <= 1'b0;
    end else begin
      key_in_q <= 1'b0;
      if (scan_done_q) begin
        unique case (state_q)
          IDLE: begin
            if (cand_valid) begin
              code_q <= cand_code;
              if (DEBOUNCE <= 4'd1) begin
                // A single scan is enough: accept right away.
                state_q    <= PRESSED;
                cnt_q      <= '0;
                key_in_q   <= 1'b1;
                key_val_q  <= cand_code;
                key_held_q <= 1'b1;
              end else begin
                state_q <= CAND;
                cnt_q   <= 4'd1;
              end
            end
          end
          CAND: begin
            if (!cand_valid) begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end else if (cand_code != code_q) begin
              code_q <= cand_code;
              cnt_q  <= 4'd1;
            end else if ((cnt_q + 4'd1) >= DEBOUNCE) begin
              state_q    <= PRESSED;
              cnt_q      <= '0;
              key_in_q   <= 1'b1;
              key_val_q  <= code_q;
              key_held_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
          PRESSED: begin
            // Any key (even a different one) keeps the press alive.
            if (cand_valid) begin
              cnt_q <= '0;
            end else if ((cnt_q + 4'd1) >= DEBOUNCE) begin
              state_q    <= IDLE;
              cnt_q      <= '0;
              key_held_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign kp.row_out  = row_out_q;
  assign kp.key_in   = key_in_q;
  assign kp.key_val  = key_val_q;
  assign kp.key_held = key_held_q;

endmodule

// File: tb/tb_keypad_scan.sv
// -----------------------------------------------------------------------------
// tb_keypad_scan
// Self-checking bench for keypad_scan with SCAN_DIV=4, DEBOUNCE=2. A keypad
// model pulls a column low when its key is pressed and its row is driven.
// A scan-level reference model predicts row_out/key_in/key_val/key_held every
// cycle; directed tests add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_keypad_scan;

  localparam int SD = 4;
  localparam int DB = 2;
  localparam int SCAN = SD * 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] pressed = '0;
  logic [3:0]  col_model;

  int checks   = 0;
  int failures = 0;
  int nstrobe  = 0;

  keypad_scan_if kif ();

  keypad_scan #(
    .SCAN_DIV (16'd4),
    .DEBOUNCE (4'd2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .kp    (kif.master)
  );

  always #5 clock = ~clock;

  // Physical keypad: a pressed key shorts its column to the driven (low) row.
  always_comb begin
    col_model = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!kif.row_out[r] && pressed[r*4+c]) col_model[c] = 1'b0;
      end
    end
  end
  assign kif.col_in = col_model;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] first_key(input logic [15:0] s);
    for (int i = 0; i < 16; i++) if (s[i]) return 4'(i);
    return 4'd0;
  endfunction

  // ---------------- reference model (scan level) ----------------
  int          k;          // clocks since reset released
  logic [15:0] ph1, ph2;   // pressed vector 1 and 2 clocks ago
  logic [15:0] m_snap;
  bit          m_held;
  int          run, empty;
  logic [3:0]  run_code;
  bit          pend, p_strobe, p_held;
  logic [3:0]  p_val;
  logic [3:0]  exp_row, exp_val;
  logic        exp_in, exp_held;
  bit          mdl_live = 0;

  always @(posedge clock) begin : mdl
    int r;
    logic [3:0] c;
    if (reset) begin
      k = 0; ph1 = '0; ph2 = '0; m_snap = '0; m_held = 0; run = 0; empty = 0;
      run_code = '0; pend = 0; p_strobe = 0; p_held = 0; p_val = '0;
      exp_row = 4'b1110; exp_in = 0; exp_val = '0; exp_held = 0; mdl_live = 1;
    end else begin
      k++;
      exp_in = 1'b0;
      if (pend) begin
        exp_in = p_strobe;
        if (p_strobe) exp_val = p_val;
        exp_held = p_held;
        pend = 0;
      end
      if (k % SD == 0) begin
        // Row r is sampled now from what the columns showed 2 clocks ago.
        r = ((k - 1) / SD) % 4;
        m_snap[r*4 +: 4] = ph2[r*4 +: 4];
        if (r == 3) begin
          p_strobe = 0;
          if (!m_held) begin
            if (m_snap != 0) begin
              c = first_key(m_snap);
              if (run > 0 && c == run_code) run++;
              else begin run = 1; run_code = c; end
              if (run >= DB) begin
                p_strobe = 1; p_val = c; m_held = 1; empty = 0; run = 0;
              end
            end else begin
              run = 0;
            end
          end else begin
            if (m_snap == 0) begin
              empty++;
              if (empty >= DB) begin m_held = 0; empty = 0; end
            end else begin
              empty = 0;
            end
          end
          p_held = m_held;
          pend = 1;
        end
      end
      ph2 = ph1;
      ph1 = pressed;
      exp_row = ~(4'b0001 << ((k / SD) % 4));
    end
  end

  // Cycle compare against the model, away from the active edge.
  always @(negedge clock) begin
    if (mdl_live) begin
      chk("row_out", kif.row_out, exp_row);
      chk("key_in", kif.key_in, exp_in);
      chk("key_val", kif.key_val, exp_val);
      chk("key_held", kif.key_held, exp_held);
    end
  end

  always @(posedge clock) if (kif.key_in === 1'b1) nstrobe++;

  // ---------------- directed stimulus ----------------
  task automatic wait_strobe(input int lim, output bit got);
    got = 0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clock);
      if (kif.key_in === 1'b1) begin got = 1; break; end
    end
  endtask

  task automatic wait_release(input int lim, output bit fell);
    fell = 0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clock);
      if (kif.key_held === 1'b0) begin fell = 1; break; end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  logic [3:0] t1_rows [20];

  initial begin : stim
    bit got, fell;
    int base;
    t1_rows = '{4'hE, 4'hE, 4'hE, 4'hD, 4'hD, 4'hD, 4'hD, 4'hB, 4'hB, 4'hB,
                4'hB, 4'h7, 4'h7, 4'h7, 4'h7, 4'hE, 4'hE, 4'hE, 4'hE, 4'hD};

    // 1. Reset, no key: row rotation and silence
    reset = 1'b1;
    idle(2);
    chk("rst_row_out", kif.row_out, 4'b1110);
    chk("rst_key_in", kif.key_in, 1'b0);
    chk("rst_key_val", kif.key_val, 4'h0);
    chk("rst_key_held", kif.key_held, 1'b0);
    reset = 1'b0;
    base = nstrobe;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      chk("t1_row_seq", kif.row_out, t1_rows[i]);
    end
    idle(480);
    chk("t1_no_strobe", nstrobe - base, 0);

    // 2. Key 6 held, then released
    base = nstrobe;
    pressed[6] = 1'b1;
    wait_strobe(50, got);
    chk("t2_strobe_seen", got, 1);
    chk("t2_key_val", kif.key_val, 4'h6);
    idle(100);
    chk("t2_one_strobe", nstrobe - base, 1);
    chk("t2_held", kif.key_held, 1'b1);
    pressed[6] = 1'b0;
    @(negedge clock);
    chk("t2_held_after_rel", kif.key_held, 1'b1);
    idle(59);
    chk("t2_held_fell", kif.key_held, 1'b0);
    idle(20);

    // 3. Keys 9 and 5 together: lowest index wins
    base = nstrobe;
    pressed[9] = 1'b1;
    pressed[5] = 1'b1;
    wait_strobe(70, got);
    chk("t3_strobe_seen", got, 1);
    chk("t3_key_val", kif.key_val, 4'h5);
    idle(100);
    chk("t3_one_strobe", nstrobe - base, 1);
    pressed = '0;
    wait_release(60, fell);
    chk("t3_released", fell, 1);
    idle(20);

    // 4. Key 3 bounces for 40 clocks, then settles pressed
    for (int i = 0; i < 200; i++) begin
      if (k % SCAN == 0) break;
      @(negedge clock);
    end
    base = nstrobe;
    for (int t = 0; t < 40; t++) begin
      pressed[3] = ((t / 3) % 2 == 0);
      @(negedge clock);
    end
    chk("t4_no_bounce_strobe", nstrobe - base, 0);
    pressed[3] = 1'b1;
    wait_strobe(70, got);
    chk("t4_strobe_seen", got, 1);
    chk("t4_key_val", kif.key_val, 4'h3);
    idle(50);
    chk("t4_one_strobe", nstrobe - base, 1);
    pressed = '0;
    wait_release(60, fell);
    chk("t4_released", fell, 1);
    idle(20);

    // 5. Reset one clock before the strobe for key F
    base = nstrobe;
    pressed[15] = 1'b1;
    got = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clock);
      if (pend && p_strobe) begin got = 1; break; end
    end
    chk("t5_strobe_due", got, 1);
    reset = 1'b1;
    @(negedge clock);
    chk("t5_rst_key_in", kif.key_in, 1'b0);
    chk("t5_rst_row_out", kif.row_out, 4'b1110);
    chk("t5_rst_key_val", kif.key_val, 4'h0);
    chk("t5_rst_key_held", kif.key_held, 1'b0);
    pressed[15] = 1'b0;
    reset = 1'b0;
    idle(40);
    chk("t5_no_strobe", nstrobe - base, 0);
    pressed[15] = 1'b1;
    wait_strobe(50, got);
    chk("t5_strobe_seen", got, 1);
    chk("t5_key_val", kif.key_val, 4'hF);
    pressed = '0;
    wait_release(60, fell);
    chk("t5_released", fell, 1);
    idle(20);

    // 6. Press 1, release, press 1 again
    base = nstrobe;
    pressed[1] = 1'b1;
    wait_strobe(50, got);
    chk("t6_first_strobe", got, 1);
    chk("t6_first_val", kif.key_val, 4'h1);
    pressed[1] = 1'b0;
    wait_release(60, fell);
    chk("t6_held_fell", fell, 1);
    idle(20);
    pressed[1] = 1'b1;
    wait_strobe(50, got);
    chk("t6_second_strobe", got, 1);
    chk("t6_second_val", kif.key_val, 4'h1);
    idle(5);
    chk("t6_two_strobes", nstrobe - base, 2);
    pressed = '0;
    idle(60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
